tt_uio_arbiter: RTL and testbench
=================================

Name: tt_uio_arbiter

Overview:
Shares the 8 bidirectional uio pins of the tt_um_Falcon top between N internal requesters (e.g. debug port, SPI master, status streamer). Grants are round-robin and whole-burst, with a forced all-inputs turnaround gap between owners so no two drivers ever overlap on the pads. Sits directly in front of the top-level uio_out/uio_oe ports. uio_in is broadcast to every requester.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, maximum granted cycles per burst; used only with the timeout feature
TURNAROUND, 1, cycles with uio_oe=0 between two owners (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  N_REQ  per-requester ownership request, level
last  in  N_REQ  owner marks its final beat; honoured only from the current owner
dout  in  8*N_REQ  per-requester output byte, requester i at bits [8i+7:8i]
doe  in  8*N_REQ  per-requester output enables, same packing
gnt  out  N_REQ  one-hot grant, registered
uio_out  out  8  pad output byte, registered
uio_oe  out  8  pad output enables, registered
din  out  8  uio_in passed through combinationally to all requesters
uio_in  in  8  pad input byte
busy  out  1  high in GRANT and TURN
timeout_evt  out  1  one-cycle pulse on forced revoke; tied 0 without the macro

Behaviour:
- Reset (rst high at a clk edge): gnt=0, uio_out=0, uio_oe=0, busy=0, timeout_evt=0, state=IDLE, rr pointer=0, burst counter=0. Reset mid-burst takes effect at that edge; the pads are released on the next cycle.
- FSM states: IDLE, GRANT, TURN.
- IDLE: if any req, pick the first set bit at or after the rr pointer (wrapping). At the edge: gnt<=onehot(winner), owner<=winner, rr pointer<=(winner+1) mod N_REQ, state<=GRANT. With no req, stay in IDLE.
- GRANT: each cycle uio_out<=dout[owner], uio_oe<=doe[owner]. Pad values lag owner inputs by 1 cycle.
- GRANT exit: when the owner has last=1, or req[owner]=0, or a timeout occurs. At that edge: gnt<=0, uio_oe<=0, uio_out<=0, state<=TURN, turnaround counter<=TURNAROUND-1. A last beat's data is still captured at that same edge, so it appears on the pads for 1 cycle. Because uio_oe is registered, the captured last beat and the uio_oe<=0 release cannot share one edge; the implementation defines the exact ordering and it must keep the last beat visible for one full cycle.
- TURN: uio_oe held 0; when the counter reaches 0, state<=IDLE. Worst-case gap between owners' pad drive is TURNAROUND+1 cycles, and it is never 0.
- req, last or dout from non-owners are ignored. Simultaneous last and deassert of req is a single exit.
- A requester that keeps req high is regranted only after all other pending requesters have been served (fairness).
- Burst counter: clears on grant and increments each GRANT cycle; it saturates.

Optional Feature:
UIO_ARB_TIMEOUT_EN
- Defined: when the burst counter reaches MAX_BURST-1 in GRANT, the owner is forcibly revoked through the normal exit path, and timeout_evt pulses for 1 cycle in the same cycle gnt drops.
- Undefined: no revoke; the owner holds the pads until last or req drops. timeout_evt is tied 0.

Decomposition:
- Package tt_uio_arb_pkg: state enum (IDLE, GRANT, TURN), state width constant, and a byte-width constant of 8.
- One combinational sub-module tt_rr_pick: inputs req vector and pointer; outputs winner index and valid. It is reusable for other arbiters in the design.

Test Plan:
- Reset: hold rst 2 cycles with req=4'hF -> gnt=0, uio_oe=00, busy=0. After release, gnt=0001 one cycle later.
- Single burst: req[0]=1, dout0=A5, doe0=FF, last on the 3rd gnt cycle -> gnt[0] for 3 cycles, uio_out=A5/oe=FF for 3 cycles lagging by 1, then uio_oe=00 for at least 1 cycle, busy drops.
- Round-robin: req=4'hF held, each owner pulses last on its first beat -> grant order 0,1,2,3,0, each separated by TURN.
- Contention guard: req1 and req2 both high with doe=FF -> no cycle where uio_oe is nonzero while the owner changes. There is at least TURNAROUND cycles of uio_oe=00 between the two bursts.
- Mid-burst reset: assert rst in the 2nd GRANT cycle of owner 2 -> next cycle gnt=0, uio_oe=00. The next grant goes to requester 0, since the pointer is reset.
- Timeout (macro defined, MAX_BURST=16): req[0] held with no last, req[1] pending -> gnt[0] high exactly 16 cycles, timeout_evt pulses once, gnt[1] follows after TURN. Without the macro, gnt[0] stays high for 40 cycles and timeout_evt stays 0.

Source files
------------

// File: rtl/tt_uio_arb_pkg.sv
// Shared types and constants for the uio pad arbiter and its helpers.
package tt_uio_arb_pkg;

    localparam int STATE_W = 2;
    localparam int BYTE_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/tt_uio_arbiter_if.sv
// Bus bundle between the uio arbiter (slave) and its requesters/pads (master).
interface tt_uio_arbiter_if
    import tt_uio_arb_pkg::*;
#(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        last;
    logic [BYTE_W*N_REQ-1:0] dout;
    logic [BYTE_W*N_REQ-1:0] doe;
    logic [N_REQ-1:0]        gnt;
    logic [BYTE_W-1:0]       uio_out;
    logic [BYTE_W-1:0]       uio_oe;
    logic [BYTE_W-1:0]       din;
    logic [BYTE_W-1:0]       uio_in;
    logic                    busy;
    logic                    timeout_evt;

    modport slave (
        input  req, last, dout, doe, uio_in,
        output gnt, uio_out, uio_oe, din, busy, timeout_evt
    );

    modport master (
        output req, last, dout, doe, uio_in,
        input  gnt, uio_out, uio_oe, din, busy, timeout_evt
    );

endinterface

// File: rtl/tt_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module tt_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          valid
);

    // rot[k] is the request that sits k positions after the pointer.
    logic [N-1:0]  rot;
    logic [IW-1:0] idx [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [IW:0] sum;
            assign sum     = {1'b0, ptr} + (IW+1)'(gi);
            assign idx[gi] = IW'((sum >= (IW+1)'(N)) ? sum - (IW+1)'(N) : sum);
            assign rot[gi] = req[idx[gi]];
        end
    endgenerate

    // Scan from the far end so the lowest rotated offset wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid  = 1'b1;
                winner = idx[k];
            end
        end
    end

endmodule

// File: rtl/tt_uio_arbiter.sv
// Round-robin, whole-burst owner arbitration of the 8 uio pads with a forced
// all-inputs turnaround between owners. Optional burst limit: UIO_ARB_TIMEOUT_EN.
module tt_uio_arbiter
    import tt_uio_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 16,
    parameter int TURNAROUND = 1
) (
    input  logic           clk,
    input  logic           rst,
    tt_uio_arbiter_if.slave bus
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TURNAROUND + 1);

    arb_state_t         state_reg;
    logic [IW-1:0]      owner_reg;
    logic [IW-1:0]      ptr_reg;
    logic [N_REQ-1:0]   gnt_reg;
    logic [BYTE_W-1:0]  uio_out_reg;
    logic [BYTE_W-1:0]  uio_oe_reg;
    logic [CW-1:0]      burst_cnt_reg;
    logic [TW-1:0]      turn_cnt_reg;

    logic [IW-1:0]      pick_winner;
    logic               pick_valid;
    logic [BYTE_W-1:0]  dout_arr [N_REQ];
    logic [BYTE_W-1:0]  doe_arr  [N_REQ];
    logic               owner_last;
    logic               owner_req;
    logic               natural_exit;
    logic               timeout_hit;
    logic               grant_exit;
    logic               keep_beat;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign dout_arr[gi] = bus.dout[BYTE_W*gi +: BYTE_W];
            assign doe_arr[gi]  = bus.doe[BYTE_W*gi +: BYTE_W];
        end
    endgenerate

    tt_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_reg),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    assign owner_last   = bus.last[owner_reg];
    assign owner_req    = bus.req[owner_reg];
    assign natural_exit = owner_last | ~owner_req;
    assign grant_exit   = natural_exit | timeout_hit;
    // A beat is worth showing on exit if the owner flagged it as last or was
    // still requesting (forced revoke); a dropped request carries no data.
    assign keep_beat    = owner_last | owner_req;

`ifdef UIO_ARB_TIMEOUT_EN
    logic timeout_evt_reg;

    assign timeout_hit     = (burst_cnt_reg == CW'(MAX_BURST - 1));
    assign bus.timeout_evt = timeout_evt_reg;

    // Pulse together with the grant drop only when the limit forced the exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_evt_reg <= 1'b0;
        end else begin
            timeout_evt_reg <= (state_reg == GRANT) && timeout_hit && !natural_exit;
        end
    end
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_evt = 1'b0;
`endif

    // Arbitration FSM; the last beat is registered at the exit edge and the
    // pads are released one edge later from TURN, so it stays a full cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            ptr_reg       <= '0;
            gnt_reg       <= '0;
            uio_out_reg   <= '0;
            uio_oe_reg    <= '0;
            burst_cnt_reg <= '0;
            turn_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    uio_out_reg <= '0;
                    uio_oe_reg  <= '0;
                    if (pick_valid) begin
                        gnt_reg       <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_winner;
                        owner_reg     <= pick_winner;
                        ptr_reg       <= (pick_winner == IW'(N_REQ - 1)) ? '0 : pick_winner + 1'b1;
                        burst_cnt_reg <= '0;
                        state_reg     <= GRANT;
                    end
                end
                GRANT: begin
                    if (burst_cnt_reg != '1) begin
                        burst_cnt_reg <= burst_cnt_reg + 1'b1;
                    end
                    if (grant_exit) begin
                        gnt_reg      <= '0;
                        turn_cnt_reg <= TW'(TURNAROUND - 1);
                        state_reg    <= TURN;
                        uio_out_reg  <= keep_beat ? dout_arr[owner_reg] : '0;
                        uio_oe_reg   <= keep_beat ? doe_arr[owner_reg]  : '0;
                    end else begin
                        uio_out_reg  <= dout_arr[owner_reg];
                        uio_oe_reg   <= doe_arr[owner_reg];
                    end
                end
                TURN: begin
                    uio_out_reg <= '0;
                    uio_oe_reg  <= '0;
                    if (turn_cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        turn_cnt_reg <= turn_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    gnt_reg     <= '0;
                    uio_out_reg <= '0;
                    uio_oe_reg  <= '0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_reg;
    assign bus.uio_out = uio_out_reg;
    assign bus.uio_oe  = uio_oe_reg;
    assign bus.busy    = (state_reg != IDLE);
    assign bus.din     = bus.uio_in;

endmodule

// File: tb/tb_tt_uio_arbiter.sv
// Directed self-checking bench for tt_uio_arbiter (N_REQ=4, MAX_BURST=16,
// TURNAROUND=1). Timeout expectations follow UIO_ARB_TIMEOUT_EN.
module tb_tt_uio_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    tt_uio_arbiter_if #(.N_REQ(4)) bus ();

    tt_uio_arbiter #(
        .N_REQ      (4),
        .MAX_BURST  (16),
        .TURNAROUND (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req  = '0;
        bus.last = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        int evt_n;
        int n;
        int last11;
        int first22;

        bus.req    = '0;
        bus.last   = '0;
        bus.dout   = '0;
        bus.doe    = '0;
        bus.uio_in = '0;

        // ---- Reset held with all requests pending ----
        bus.req = 4'hF;
        tick();
        tick();
        check("rst_gnt", bus.gnt, 4'h0);
        check("rst_oe", bus.uio_oe, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_evt", bus.timeout_evt, 1'b0);
        rst = 1'b0;
        tick();
        check("post_rst_gnt", bus.gnt, 4'b0001);
        check("post_rst_busy", bus.busy, 1'b1);
        $display("[TB] reset: first grant gnt=%b", bus.gnt);

        // ---- din pass-through ----
        bus.uio_in = 8'h3C;
        #1;
        check("din_3c", bus.din, 8'h3C);
        bus.uio_in = 8'hC3;
        #1;
        check("din_c3", bus.din, 8'hC3);

        // ---- Single burst, last on the third granted cycle ----
        do_reset();
        bus.dout = 32'h0000_00A5;
        bus.doe  = 32'h0000_00FF;
        bus.req  = 4'b0001;
        tick();
        check("sb_gnt1", bus.gnt, 4'b0001);
        check("sb_oe1", bus.uio_oe, 8'h00);
        tick();
        check("sb_gnt2", bus.gnt, 4'b0001);
        check("sb_out2", bus.uio_out, 8'hA5);
        check("sb_oe2", bus.uio_oe, 8'hFF);
        tick();
        check("sb_gnt3", bus.gnt, 4'b0001);
        check("sb_out3", bus.uio_out, 8'hA5);
        bus.last = 4'b0001;
        tick();
        bus.last = 4'b0000;
        bus.req  = 4'b0000;
        check("sb_gnt_drop", bus.gnt, 4'b0000);
        check("sb_last_out", bus.uio_out, 8'hA5);
        check("sb_last_oe", bus.uio_oe, 8'hFF);
        check("sb_busy_turn", bus.busy, 1'b1);
        tick();
        check("sb_rel_oe", bus.uio_oe, 8'h00);
        check("sb_rel_out", bus.uio_out, 8'h00);
        check("sb_busy_drop", bus.busy, 1'b0);
        $display("[TB] single burst done");

        // ---- Round robin, one-beat bursts ----
        do_reset();
        bus.dout = 32'h1312_1110;
        bus.doe  = 32'hFFFF_FFFF;
        bus.req  = 4'hF;
        bus.last = 4'hF;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (bus.gnt == 4'b0000 && n < 6) begin
                tick();
                n++;
            end
            check("rr_gnt", bus.gnt, 32'(1) << (k % 4));
            $display("[TB] rr burst %0d gnt=%b", k, bus.gnt);
            tick();
            check("rr_beat", bus.uio_out, 8'h10 + 8'(k % 4));
            check("rr_turn_gnt", bus.gnt, 4'b0000);
        end

        // ---- Contention guard between owners 1 and 2 ----
        do_reset();
        bus.dout = 32'h0022_1100;
        bus.doe  = 32'h00FF_FF00;
        bus.last = 4'b0000;
        bus.req  = 4'b0110;
        last11  = -1;
        first22 = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.uio_oe != 8'h00 && bus.uio_out == 8'h11) last11 = i;
            if (bus.uio_oe != 8'h00 && bus.uio_out == 8'h22 && first22 < 0) first22 = i;
            if (i == 2) bus.last = 4'b0010;
            if (i == 3) bus.last = 4'b0000;
        end
        check("cg_last11", 32'(last11), 32'd3);
        check("cg_first22", 32'(first22), 32'd6);
        check("cg_gap", 32'(first22 - last11 - 1), 32'd2);
        $display("[TB] contention: owner1 last drive %0d, owner2 first drive %0d", last11, first22);

        // ---- Mid-burst reset of owner 2 ----
        do_reset();
        bus.dout = 32'h0077_0000;
        bus.doe  = 32'h00FF_0000;
        bus.req  = 4'b0100;
        tick();
        check("mr_gnt", bus.gnt, 4'b0100);
        tick();
        check("mr_oe", bus.uio_oe, 8'hFF);
        rst = 1'b1;
        bus.req = 4'hF;
        tick();
        rst = 1'b0;
        check("mr_gnt_rst", bus.gnt, 4'b0000);
        check("mr_oe_rst", bus.uio_oe, 8'h00);
        check("mr_busy_rst", bus.busy, 1'b0);
        tick();
        check("mr_next_gnt", bus.gnt, 4'b0001);
        $display("[TB] mid-burst reset: next gnt=%b", bus.gnt);

        // ---- Long burst from owner 0 with owner 1 pending ----
        do_reset();
        bus.last = 4'b0000;
        bus.req  = 4'b0011;
        tick();
        run   = 0;
        evt_n = 0;
        while (bus.gnt == 4'b0001 && run < 40) begin
            run++;
            tick();
            if (bus.timeout_evt) evt_n++;
        end
`ifdef UIO_ARB_TIMEOUT_EN
        check("to_run", 32'(run), 32'd16);
        check("to_evt_n", 32'(evt_n), 32'd1);
        check("to_evt_now", bus.timeout_evt, 1'b1);
        tick();
        check("to_evt_clear", bus.timeout_evt, 1'b0);
        tick();
        check("to_next_gnt", bus.gnt, 4'b0010);
`else
        check("nt_run", 32'(run), 32'd40);
        check("nt_evt_n", 32'(evt_n), 32'd0);
        check("nt_gnt_held", bus.gnt, 4'b0001);
        check("nt_evt_now", bus.timeout_evt, 1'b0);
`endif
        $display("[TB] long burst: owner0 held %0d cycles, %0d timeout events", run, evt_n);

        bus.req = 4'b0000;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
